// File: rtl/uart_tx_core.sv
// ----------------------------------------------------------------------------
// uart_tx_core
//
// Transmit half of a UART link. One parallel word is accepted per handshake
// while idle, then a frame is serialized at one bit per clk cycle:
// start (0), data LSB first, optional parity, stop (1). clk is already the
// baud-rate bit clock.
//
// Parameters:
//   frame_data  data bits per frame (>= 2)
//   bit_cnt_w   data-bit counter width, 2**bit_cnt_w >= frame_data
//
// Ports:
//   clk         bit clock, rising edge
//   rst         synchronous active-high reset; aborts any frame in flight
//   p_data      parallel word to transmit
//   data_valid  word-offer strobe, accepted only in IDLE
//   par_en      1 = append a parity bit after the data bits
//   par_typ     0 = even parity, 1 = odd parity
//   tx_out      serial line, idles high (registered)
//   busy        high from start bit through stop bit inclusive (registered)
// ----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int frame_data = 8,
    parameter int bit_cnt_w  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [frame_data-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Counter value while the last data bit is on the line.
    localparam logic [bit_cnt_w-1:0] last_bit = bit_cnt_w'(frame_data - 1);

    state_t                  state_q;
    logic [bit_cnt_w-1:0]    cnt_q;      // index of the data bit currently on the line
    logic [frame_data-1:0]   data_q;     // latched word, shifted right as bits go out
    logic                    par_en_q;   // latched parity enable
    logic                    par_bit_q;  // parity bit, fixed at acceptance
    logic                    tx_q;
    logic                    busy_q;

    // Outputs come straight from flops so the line never glitches on input
    // activity. Each branch loads tx_q with the value the line must show
    // during the state being entered.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        state_q   <= START;
                        data_q    <= p_data;
                        par_en_q  <= par_en;
                        // Even parity is the XOR of the word; odd inverts it.
                        par_bit_q <= (^p_data) ^ par_typ;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    tx_q    <= data_q[0];
                    data_q  <= data_q >> 1;
                end

                DATA: begin
                    if (cnt_q == last_bit) begin
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_q + bit_cnt_w'(1);
                        tx_q   <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end

                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end

                STOP: begin
                    // busy drops on the same edge the line leaves the stop bit.
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_core
//
// Self-checking bench for uart_tx_core (8 data bits). When the driver knows a
// word is accepted it pushes the expected per-cycle {tx_out, busy} pairs of
// the whole frame into a queue. A monitor on the falling edge pops one pair
// per cycle and compares; with the queue empty it requires the idle line
// (tx_out=1, busy=0).
// ----------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [FD-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          tx_out;
    logic          busy;

    int            n_vectors     = 0;
    int            n_miscompares = 0;
    int            cyc           = 0;
    logic          mon_en        = 1'b0;
    logic [1:0]    mon_exp;
    logic [1:0]    exp_q[$];

    uart_tx_core #(
        .frame_data (FD),
        .bit_cnt_w  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line/busy sequence of one frame, built from the frame format.
    task automatic push_frame(input logic [FD-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(2'b01);                       // start bit
        for (int i = 0; i < FD; i++)
            exp_q.push_back({d[i], 1'b1});            // data, LSB first
        if (pe)
            exp_q.push_back({(^d) ^ pt, 1'b1});       // parity
        exp_q.push_back(2'b11);                       // stop bit
    endtask

    // Called at a rising edge with the DUT idle: offer the word for one edge,
    // record the expected frame, then wait 'gap' more edges.
    task automatic offer(input logic [FD-1:0] d, input logic pe, input logic pt, input int gap);
        #1;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        push_frame(d, pe, pt);
        data_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 2'b10;
            check($sformatf("cyc%0d tx_out/busy", cyc), {30'd0, tx_out, busy}, {30'd0, mon_exp});
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        p_data     = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        // Reset for 3 edges, then 20 idle cycles.
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        offer(8'hA5, 1'b0, 1'b0, 12);

        // Parity on 0x07: even -> 1, odd -> 0; 11-cycle frames.
        offer(8'h07, 1'b1, 1'b0, 13);
        offer(8'h07, 1'b1, 1'b1, 13);

        // data_valid held high: 0x01 then 0xFF, period 11 with one idle cycle.
        // p_data switches to 0xFF right after the first acceptance.
        #1;
        p_data     = 8'h01;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        push_frame(8'h01, 1'b0, 1'b0);
        p_data = 8'hFF;
        repeat (11) @(posedge clk);
        #1;
        push_frame(8'hFF, 1'b0, 1'b0);
        data_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Abort: reset sampled while data bit 3 of 0x00 is on the line.
        #1;
        p_data     = 8'h00;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        push_frame(8'h00, 1'b0, 1'b0);
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();                               // remaining bits never appear
        repeat (2) @(posedge clk);
        offer(8'h3C, 1'b0, 1'b0, 12);

        // Reset and data_valid together: reset wins, no frame.
        #1;
        rst        = 1'b1;
        p_data     = 8'hAA;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        data_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Ignored offer: 0x55 pulsed mid-frame of an 8O1 0xC3 frame.
        #1;
        p_data     = 8'hC3;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        push_frame(8'hC3, 1'b1, 1'b1);
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (20) @(posedge clk);

        #1;
        check("expected queue drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART serializer forming the transmit half of the UART link. It accepts one parallel data word per handshake, then serializes a frame onto `tx_out` at one bit per `clk` cycle: start bit, data LSB first, optional parity bit, stop bit. `clk` is the transmit bit clock, already divided to the baud rate upstream. The block is fed by the system controller and drives the serial line read by the receiver on the far side.

## Interface

- `frame_data`, default 8: data bits per frame (≥2).
- `bit_cnt_w`, default 4: data-bit counter width; must satisfy 2^`bit_cnt_w` ≥ `frame_data`.
- `clk`  in  1  single clock, rising edge; one serial bit per cycle.
- `rst`  in  1  reset, synchronous and active-high.
- `p_data`  in  `frame_data`  parallel word to transmit.
- `data_valid`  in  1  word-offer strobe; accepted only when idle.
- `par_en`  in  1  1 = insert a parity bit after the data bits.
- `par_typ`  in  1  0 = even parity, 1 = odd parity.
- `tx_out`  out  1  serial line; idles high.
- `busy`  out  1  high from start bit through stop bit inclusive.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- IDLE: `tx_out`=1, `busy`=0. If `data_valid`=1 at an edge, the block latches `p_data`, `par_en`, and `par_typ` into holding registers and moves to START.
- START: `tx_out`=0. Next state is DATA, with the bit counter cleared to 0.
- DATA: `tx_out` = latched bit [counter]. The counter increments each cycle. When counter = `frame_data`-1, the next state is PARITY if latched `par_en`=1, else STOP.
- PARITY: `tx_out` = XOR of the latched word for even parity, or its inverse for odd parity. Next state is STOP.
- STOP: `tx_out`=1. Next state is IDLE unconditionally. `data_valid` is ignored in this state.
- `data_valid` is ignored in every non-IDLE state. There is no queueing; the source must hold or re-offer the word until `busy`=0.
- Input changes on `p_data`, `par_en`, or `par_typ` after acceptance have no effect on the frame in flight.
- Parity is computed from the latched word, either combinationally from the holding register or registered at acceptance. The value on the line must match the rule above.
- `tx_out` and `busy` are registered outputs with no combinational path from inputs.

## Timing

- Reset: on any edge with `rst`=1, state becomes IDLE, `tx_out`=1, `busy`=0, and the counter and holding registers clear to 0. Reset applied mid-frame aborts the frame; the line returns high in the next cycle. No partial stop bit is generated.
- Let E0 be the accepting edge (state IDLE, `data_valid`=1). Output after each edge:
  - after E0: start bit; `busy` rises.
  - after E1..E`frame_data`: data bits 0..`frame_data`-1.
  - then one parity cycle if enabled.
  - then one stop cycle with `busy`=1.
  - then IDLE with `busy`=0.
- Frame length is 10 cycles for 8N1 and 11 cycles for 8E1/8O1, measured start through stop.
- Back-to-back transfers have a minimum of one idle-high cycle between frames. With `data_valid` held high continuously, the frame-to-frame period is 11 cycles (no parity) or 12 cycles (parity).
- `busy` falls on the same edge at which `tx_out` leaves the stop bit.
- Simultaneous `rst`=1 and `data_valid`=1: reset wins and the word is not accepted.

## Test plan

- Reset then idle: hold `rst`=1 for 3 cycles, then release with `data_valid`=0 for 20 cycles. Required: `tx_out`=1 and `busy`=0 throughout.
- 8N1 with `p_data`=0xA5, `par_en`=0: line sequence is 0,1,0,1,0,0,1,0,1,1. `busy` is high for exactly those 10 cycles. Line is 1 afterward.
- Parity with `p_data`=0x07, `par_en`=1: for `par_typ`=0 the parity bit is 1; for `par_typ`=1 it is 0. The frame is 11 cycles.
- Continuous `data_valid` with words 0x01 then 0xFF, no parity: second start bit occurs exactly 11 cycles after the first. There is exactly one idle-high cycle between frames. `p_data` changes mid-frame do not corrupt the first frame.
- Abort: assert `rst` during data bit 3 of 0x00. Required: `tx_out`=1 and `busy`=0 the next cycle. A new 0x3C frame then transmits correctly.
- Ignored offer: pulse `data_valid` with 0x55 while `busy`=1. Required: no extra frame, and the in-flight frame is unchanged.
